// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and constants for the program sequencer.
package cpu_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SETUP, EXEC, RECOVER, DONE} state_t;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] operand;
  } instr_t;
  localparam instr_t RESET_WORD = 12'hF00;
endpackage

// File: rtl/cpu_program_sequencer_if.sv
// cpu_program_sequencer_if: board/CPU-facing signals of the program sequencer.
interface cpu_program_sequencer_if;
  logic        start;
  logic        halt_req;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_word;
  logic        c_flag;
  logic        z_flag;
  logic        key_0;
  logic [3:0]  opcode;
  logic [7:0]  switch_input;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  modport master (
    output start, halt_req, load_en, load_addr, load_word, c_flag, z_flag,
    input  key_0, opcode, switch_input, pc, busy, done
  );
  modport slave (
    input  start, halt_req, load_en, load_addr, load_word, c_flag, z_flag,
    output key_0, opcode, switch_input, pc, busy, done
  );
endinterface

// File: rtl/cpu_seq_prog_mem.sv
// cpu_seq_prog_mem: 16x12 program store, one write port, registered read port.
module cpu_seq_prog_mem
  import cpu_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  instr_t     wdata,
  input  logic       re,
  input  logic [3:0] raddr,
  output instr_t     rdata
);
  instr_t mem [16];
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < 16; i++) mem[i] <= RESET_WORD;
    else if (we) mem[waddr] <= wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata <= RESET_WORD;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer: replays a stored program into the CPU control inputs,
// resolving jumps and halts locally.
module cpu_program_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input logic clock,
  input logic reset,
  cpu_program_sequencer_if.slave bus
);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  state_t     state, state_n;
  instr_t     ir;
  logic [7:0] cnt;
  logic       halt_l;
  logic       taken;
  logic       key_0;
  logic [3:0] opcode;
  logic [7:0] switch_input;
  logic [3:0] pc;
  cpu_seq_prog_mem mem (
    .clock(clock),
    .reset(reset),
    .we(bus.load_en && state == IDLE),
    .waddr(bus.load_addr),
    .wdata(bus.load_word),
    .re(state == FETCH),
    .raddr(pc),
    .rdata(ir)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = (halt_l || ir.opcode == OP_HALT) ? DONE : ir.opcode >= OP_JMP ? FETCH : SETUP;
      SETUP:   state_n = cnt == SETUP_LAST ? EXEC : SETUP;
      EXEC:    state_n = cnt == PULSE_LAST ? RECOVER : EXEC;
      RECOVER: state_n = halt_l ? DONE : FETCH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    taken = ir.opcode == OP_JMP || (ir.opcode == OP_JZ && bus.z_flag) || (ir.opcode == OP_JC && bus.c_flag);
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.key_0 = key_0;
    bus.opcode = opcode;
    bus.switch_input = switch_input;
    bus.pc = pc;
  end
  // key_0 is registered from the next state so the strobe edge is glitch-free
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      key_0        <= 1'b1;
      opcode       <= '0;
      switch_input <= '0;
      pc           <= '0;
      cnt          <= '0;
      halt_l       <= 1'b0;
    end else begin
      key_0  <= state_n != EXEC;
      cnt    <= (state_n == state && (state == SETUP || state == EXEC)) ? cnt + 8'd1 : 8'd0;
      halt_l <= (state == IDLE) ? halt_l && !bus.start : halt_l || bus.halt_req;
      if (state == IDLE && bus.start) pc <= '0;
      if (state == DECODE && state_n == FETCH) pc <= taken ? ir.operand[3:0] : pc + 4'd1;
      if (state == DECODE && state_n == SETUP) begin
        opcode       <= ir.opcode;
        switch_input <= ir.operand;
      end
      if (state == RECOVER) pc <= pc + 4'd1;
    end
endmodule
